ping_pong_buffer: RTL and testbench
===================================

# ping_pong_buffer

Ping-pong (double) buffer demonstrator: a self-generated 4-bit data stream is written alternately into two on-chip buffers, A and B. While one buffer fills, the other is read out. The block sits under a top-level on the 100 MHz board clock; its two read ports drive board-level outputs (LEDs / logic-analyzer pins). The module is named ping_pong_buffer.

## Interface
- DEPTH, 8, entries per buffer (power of two, 2..256); also the length of every fill/read phase in cycles.
- clk_100  input  1  system clock, 100 MHz nominal; all logic on its rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  run request; level sampled only in IDLE.
- douta_b  output  4  registered read data from buffer A.
- doutb_b  output  4  registered read data from buffer B.

## Operation
- Storage: two independent DEPTH x 4 memories, memA and memB (inferable as distributed/block RAM). Contents are not cleared by reset.
- Data source: 4-bit counter `din`, reset 0. It increments by 1 on every write cycle and wraps 15 -> 0.
- Phase counter `cnt`: 0..DEPTH-1, reset 0. It serves as both write and read address. It increments every cycle outside IDLE and wraps to 0 at DEPTH-1; the wrap marks the end of a phase.
- State machine (reset state IDLE):
  - IDLE: no writes or reads. If start=1 at a rising edge, go to FILL_A with cnt=0. Otherwise stay.
  - FILL_A: memA[cnt] <= din; no read. After the DEPTH-th write, go to WB_RA.
  - WB_RA: memB[cnt] <= din; douta_b <= memA[cnt]. After DEPTH cycles, go to WA_RB.
  - WA_RB: memA[cnt] <= din; doutb_b <= memB[cnt]. After DEPTH cycles, go to WB_RA.
  - WB_RA and WA_RB alternate until reset. start is ignored outside IDLE, so deasserting start does not stop operation.
- In any cycle, the buffer being written and the buffer being read are always different. No read/write collision handling is needed.
- An output register loads only in the state that reads its buffer. Otherwise it holds its last value.
- Reset values: douta_b=0, doutb_b=0, din=0, cnt=0, state=IDLE.
- Reset asserted mid-operation: on the next rising edge, all registers above return to their reset values. Memory contents persist but are overwritten before they are read again, because FILL_A always precedes any read.

## Timing
- Edge E0 samples start=1 in IDLE. The DEPTH writes of FILL_A occur at edges E1..E_DEPTH.
- The first WB_RA cycle follows edge E_DEPTH. At the edge ending WB_RA cycle k, douta_b <= memA[k]. douta_b therefore presents memA[k] during cycle k+1: one-cycle read latency.
- Each output shows a new value every cycle for DEPTH consecutive cycles, then freezes for DEPTH cycles.
- Steady-state throughput: one write and one read per clock. Each phase lasts exactly DEPTH cycles.
- The first read data appears DEPTH+1 cycles after start is sampled.

## Test plan
All scenarios use DEPTH=8 and a 20 ns clock period.
- Reset: hold rst=0 for 5 edges -> douta_b=0, doutb_b=0, and no activity.
- Idle hold: release reset with start=0 for 10 edges -> outputs stay 0 and the block remains in IDLE.
- First fill and read: raise start at edge E0 -> doutb_b stays 0; from cycle E9+1, douta_b steps 0,1,2,...,7 on consecutive cycles, then holds 7.
- Ping-pong swap: continue -> doutb_b steps 8,9,...,15 on consecutive cycles while douta_b holds 7; then douta_b steps 0..7 again (din wrapped) while doutb_b holds 15.
- Start deassert: drop start during WA_RB -> the alternating sequence continues unchanged.
- Mid-run reset: assert rst=0 for 1 edge during WB_RA -> both outputs read 0 after that edge; on restart, the first douta_b value is 0.

Source files
------------

// File: rtl/ping_pong_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ping_pong_buffer_if : run request and read-data bundle for the buffer  |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
interface ping_pong_buffer_if;
  logic       start;
  logic [3:0] douta_b;
  logic [3:0] doutb_b;

  modport master (
    output start,
    input  douta_b,
    input  doutb_b
  );

  modport slave (
    input  start,
    output douta_b,
    output doutb_b
  );
endinterface
`default_nettype wire

// File: rtl/ping_pong_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ping_pong_buffer : self-fed 4-bit stream written alternately into two  |
// | DEPTH x 4 buffers while the other buffer is read out.  Revision 1.0    |
// +-----------------------------------------------------------------------+
module ping_pong_buffer #(
  parameter int DEPTH = 8
) (
  input  wire                     clk_100,
  input  wire                     rst,
  ping_pong_buffer_if.slave       bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL_A = 2'd1;
  localparam logic [1:0] ST_WB_RA  = 2'd2;
  localparam logic [1:0] ST_WA_RB  = 2'd3;

  logic [3:0]    mem_a [DEPTH];
  logic [3:0]    mem_b [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic [3:0]    din_q,   din_d;
  logic [3:0]    douta_q, douta_d;
  logic [3:0]    doutb_q, doutb_d;
  logic          we_a, we_b;
  logic          last;

  assign last = (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    douta_d = douta_q;
    doutb_d = doutb_q;
    we_a    = 1'b0;
    we_b    = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = last ? '0 : cnt_q + AW'(1);
      din_d = din_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FILL_A;
          cnt_d   = '0;
        end
      end
      ST_FILL_A: begin
        we_a = 1'b1;
        if (last) state_d = ST_WB_RA;
      end
      ST_WB_RA: begin
        we_b    = 1'b1;
        douta_d = mem_a[cnt_q];
        if (last) state_d = ST_WA_RB;
      end
      ST_WA_RB: begin
        we_a    = 1'b1;
        doutb_d = mem_b[cnt_q];
        if (last) state_d = ST_WB_RA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= 4'd0;
      douta_q <= 4'd0;
      doutb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

  // Storage has no reset so it maps onto plain RAM; writes are blocked while in reset.
  always_ff @(posedge clk_100) begin
    if (rst && we_a) mem_a[cnt_q] <= din_q;
    if (rst && we_b) mem_b[cnt_q] <= din_q;
  end

  assign bus.douta_b = douta_q;
  assign bus.doutb_b = doutb_q;

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_buffer.sv
`default_nettype none
// Self-checking bench for ping_pong_buffer: a time-indexed buffer model plus
// literal checkpoints along the first fill/read/swap sequence.
module tb_ping_pong_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ping_pong_buffer_if bus ();

  ping_pong_buffer #(.DEPTH(DEPTH)) dut (
    .clk_100 (clk),
    .rst     (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  // Model: after start, active cycle t is phase t/DEPTH at slot t%DEPTH,
  // carrying data t%16. Phase 0 fills A, odd phases read A / write B,
  // even phases after 0 read B / write A.
  logic [3:0] ma [DEPTH];
  logic [3:0] mb [DEPTH];
  logic [3:0] exp_a = 4'd0;
  logic [3:0] exp_b = 4'd0;
  bit         running = 1'b0;
  int         t = 0;

  always @(posedge clk) begin
    int phase, pos;
    logic [3:0] d;
    if (!rst_n) begin
      running = 1'b0;
      t       = 0;
      exp_a   = 4'd0;
      exp_b   = 4'd0;
    end else if (!running) begin
      if (bus.start) begin
        running = 1'b1;
        t       = 0;
      end
    end else begin
      phase = t / DEPTH;
      pos   = t % DEPTH;
      d     = 4'(t % 16);
      if (phase == 0) begin
        ma[pos] = d;
      end else if (phase % 2 == 1) begin
        exp_a   = ma[pos];
        mb[pos] = d;
      end else begin
        exp_b   = mb[pos];
        ma[pos] = d;
      end
      t++;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_douta", bus.douta_b, exp_a);
      check("model_doutb", bus.doutb_b, exp_b);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    rst_n     = 1'b0;
    edges(1);
    cmp_en = 1'b1;
    edges(4);
    check("reset_douta", bus.douta_b, 4'd0);
    check("reset_doutb", bus.doutb_b, 4'd0);

    @(negedge clk) rst_n = 1'b1;
    edges(10);
    check("idle_douta", bus.douta_b, 4'd0);
    check("idle_doutb", bus.doutb_b, 4'd0);

    @(negedge clk) bus.start = 1'b1;
    edges(1);                       // E0
    edges(9);                       // E9
    check("first_read_a0", bus.douta_b, 4'd0);
    check("first_read_b_hold", bus.doutb_b, 4'd0);
    edges(7);                       // E16
    check("first_read_a7", bus.douta_b, 4'd7);
    edges(1);                       // E17
    check("swap_b8", bus.doutb_b, 4'd8);
    check("swap_a_hold7", bus.douta_b, 4'd7);

    @(negedge clk) bus.start = 1'b0;
    edges(7);                       // E24
    check("swap_b15", bus.doutb_b, 4'd15);
    edges(1);                       // E25
    check("wrap_a0", bus.douta_b, 4'd0);
    edges(7);                       // E32
    check("wrap_a7", bus.douta_b, 4'd7);
    check("wrap_b_hold15", bus.doutb_b, 4'd15);

    edges(10);                      // E42, inside a B-write / A-read phase
    @(negedge clk) rst_n = 1'b0;
    edges(1);
    check("midrst_douta", bus.douta_b, 4'd0);
    check("midrst_doutb", bus.doutb_b, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    edges(3);
    @(negedge clk) bus.start = 1'b1;
    edges(10);
    check("restart_a0", bus.douta_b, 4'd0);
    check("restart_b0", bus.doutb_b, 4'd0);

    repeat (600) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 199) < 3) ? 1'b0 : 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    edges(2);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
